// File: rtl/mem_xbar_n.sv
// mem_xbar_n: routes one CPU data-port word request to one of NUM_REGIONS
// memory targets, with a valid/ready request handshake, multi-cycle target
// responses, an error response for unmapped addresses and a per-transaction
// timeout. One transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_req_valid        CPU request valid; accepted when o_req_ready is high
//   i_addr/i_data      word address / write data
//   i_wren/i_mask      write enable / byte-enable mask
//   o_rsp_valid        one-cycle response pulse
//   o_rsp_data/err     response data / unmapped-or-timeout error (held)
//   o_tgt_*            request to the selected target (one-hot valid,
//                      region-relative address, latched data/wren/mask)
//   i_tgt_ready        per-target request accept
//   i_tgt_rsp_valid    per-target read data valid
//   i_tgt_rsp_data     per-target read data, packed 32 bits per target
module mem_xbar_n #(
  parameter int unsigned                   NUM_REGIONS  = 2,
  parameter logic [NUM_REGIONS*30-1:0]     REGION_BASE  = {30'h00400, 30'h00000},
  parameter logic [NUM_REGIONS*30-1:0]     REGION_LIMIT = {30'h00500, 30'h00400},
  parameter int unsigned                   TIMEOUT      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [29:0]               i_addr,
  input  logic [31:0]               i_data,
  input  logic                      i_wren,
  input  logic [3:0]                i_mask,
  output logic                      o_rsp_valid,
  output logic [31:0]               o_rsp_data,
  output logic                      o_rsp_err,
  output logic [NUM_REGIONS-1:0]    o_tgt_valid,
  output logic [29:0]               o_tgt_addr,
  output logic [31:0]               o_tgt_data,
  output logic                      o_tgt_wren,
  output logic [3:0]                o_tgt_mask,
  input  logic [NUM_REGIONS-1:0]    i_tgt_ready,
  input  logic [NUM_REGIONS-1:0]    i_tgt_rsp_valid,
  input  logic [NUM_REGIONS*32-1:0] i_tgt_rsp_data
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
  // Last counter value at which the target may still complete.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_REGIONS-1:0]   tgt_valid_q, tgt_valid_d;
  logic [29:0]              tgt_addr_q, tgt_addr_d;
  logic [31:0]              tgt_data_q, tgt_data_d;
  logic                     tgt_wren_q, tgt_wren_d;
  logic [3:0]               tgt_mask_q, tgt_mask_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [31:0]              rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     hit;
  logic [IDX_W-1:0]         hit_idx;
  logic [29:0]              hit_off;
  logic [NUM_REGIONS-1:0]   hit_oh;
  logic                     sel_ready;
  logic                     sel_rsp_valid;
  logic [31:0]              sel_rsp_data;
  logic                     timeout_hit;
  logic [CNT_W-1:0]         cnt_inc;

  // Address decode: first matching region in ascending index order wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = i_addr;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      if (!hit && (i_addr >= REGION_BASE[30*k +: 30]) &&
          (i_addr < REGION_LIMIT[30*k +: 30])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
        hit_off = i_addr - REGION_BASE[30*k +: 30];
      end
    end
  end

  always_comb begin
    hit_oh = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      hit_oh[k] = hit && (hit_idx == IDX_W'(k));
    end
  end

  // Only the latched target's handshake/response signals are observed.
  always_comb begin
    sel_ready     = 1'b0;
    sel_rsp_valid = 1'b0;
    sel_rsp_data  = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready     = i_tgt_ready[k];
        sel_rsp_valid = i_tgt_rsp_valid[k];
        sel_rsp_data  = i_tgt_rsp_data[32*k +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);
  assign cnt_inc     = (TIMEOUT != 0) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_valid_d = tgt_valid_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_data_d  = tgt_data_q;
    tgt_wren_d  = tgt_wren_q;
    tgt_mask_d  = tgt_mask_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          idx_d      = hit_idx;
          tgt_addr_d = hit_off;
          tgt_data_d = i_data;
          tgt_wren_d = i_wren;
          tgt_mask_d = i_mask;
          if (hit) begin
            state_d     = S_REQ;
            tgt_valid_d = hit_oh;
            cnt_d       = '0;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        if (sel_ready) begin
          tgt_valid_d = '0;
          if (tgt_wren_q) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end else if (sel_rsp_valid) begin
            // Zero-latency target: response rides along with the handshake.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = sel_rsp_data;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          tgt_valid_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        if (sel_rsp_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = sel_rsp_data;
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tgt_valid_q <= '0;
      tgt_addr_q  <= '0;
      tgt_data_q  <= '0;
      tgt_wren_q  <= 1'b0;
      tgt_mask_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_data_q  <= tgt_data_d;
      tgt_wren_q  <= tgt_wren_d;
      tgt_mask_q  <= tgt_mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted.
  assign o_req_ready = rst_n && (state_q == S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_tgt_valid = tgt_valid_q;
  assign o_tgt_addr  = tgt_addr_q;
  assign o_tgt_data  = tgt_data_q;
  assign o_tgt_wren  = tgt_wren_q;
  assign o_tgt_mask  = tgt_mask_q;

endmodule

// File: tb/tb_mem_xbar_n.sv
module tb_mem_xbar_n;

  localparam int NR = 2;
  localparam int TO = 16;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid;
  logic [29:0]     addr;
  logic [31:0]     wdata;
  logic            wren;
  logic [3:0]      mask;
  logic [NR-1:0]   tgt_ready;
  logic [NR-1:0]   tgt_rsp_valid;
  logic [NR*32-1:0] tgt_rsp_data;

  // Outputs of the default-map instance (a) and the overlapping-map instance (b)
  logic            a_req_ready, b_req_ready;
  logic            a_rsp_valid, b_rsp_valid;
  logic [31:0]     a_rsp_data, b_rsp_data;
  logic            a_rsp_err, b_rsp_err;
  logic [NR-1:0]   a_tgt_valid, b_tgt_valid;
  logic [29:0]     a_tgt_addr, b_tgt_addr;
  logic [31:0]     a_tgt_data, b_tgt_data;
  logic            a_tgt_wren, b_tgt_wren;
  logic [3:0]      a_tgt_mask, b_tgt_mask;

  logic            use_b = 1'b0;
  logic            m_req_ready, m_rsp_valid, m_rsp_err, m_tgt_wren;
  logic [31:0]     m_rsp_data, m_tgt_data;
  logic [NR-1:0]   m_tgt_valid;
  logic [29:0]     m_tgt_addr;
  logic [3:0]      m_tgt_mask;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mem_xbar_n #(
    .NUM_REGIONS (2),
    .REGION_BASE ({30'h00400, 30'h00000}),
    .REGION_LIMIT({30'h00500, 30'h00400}),
    .TIMEOUT     (16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(a_req_ready),
    .i_addr(addr), .i_data(wdata), .i_wren(wren), .i_mask(mask),
    .o_rsp_valid(a_rsp_valid), .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err),
    .o_tgt_valid(a_tgt_valid), .o_tgt_addr(a_tgt_addr), .o_tgt_data(a_tgt_data),
    .o_tgt_wren(a_tgt_wren), .o_tgt_mask(a_tgt_mask),
    .i_tgt_ready(tgt_ready), .i_tgt_rsp_valid(tgt_rsp_valid),
    .i_tgt_rsp_data(tgt_rsp_data)
  );

  mem_xbar_n #(
    .NUM_REGIONS (2),
    .REGION_BASE ({30'h003F0, 30'h00000}),
    .REGION_LIMIT({30'h00500, 30'h00400}),
    .TIMEOUT     (16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_addr(addr), .i_data(wdata), .i_wren(wren), .i_mask(mask),
    .o_rsp_valid(b_rsp_valid), .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err),
    .o_tgt_valid(b_tgt_valid), .o_tgt_addr(b_tgt_addr), .o_tgt_data(b_tgt_data),
    .o_tgt_wren(b_tgt_wren), .o_tgt_mask(b_tgt_mask),
    .i_tgt_ready(tgt_ready), .i_tgt_rsp_valid(tgt_rsp_valid),
    .i_tgt_rsp_data(tgt_rsp_data)
  );

  always_comb begin
    m_req_ready = use_b ? b_req_ready : a_req_ready;
    m_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
    m_rsp_data  = use_b ? b_rsp_data  : a_rsp_data;
    m_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
    m_tgt_valid = use_b ? b_tgt_valid : a_tgt_valid;
    m_tgt_addr  = use_b ? b_tgt_addr  : a_tgt_addr;
    m_tgt_data  = use_b ? b_tgt_data  : a_tgt_data;
    m_tgt_wren  = use_b ? b_tgt_wren  : a_tgt_wren;
    m_tgt_mask  = use_b ? b_tgt_mask  : a_tgt_mask;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference address map: region i covers [base, limit), first match wins.
  function automatic void ref_decode(input logic map_b, input logic [29:0] a,
                                     output bit hit, output int idx,
                                     output logic [29:0] off);
    logic [29:0] base [NR];
    logic [29:0] limit [NR];
    base[0]  = 30'h00000;
    base[1]  = map_b ? 30'h003F0 : 30'h00400;
    limit[0] = 30'h00400;
    limit[1] = 30'h00500;
    hit = 0;
    idx = 0;
    off = a;
    for (int i = 0; i < NR; i++) begin
      if (!hit && a >= base[i] && a < limit[i]) begin
        hit = 1;
        idx = i;
        off = a - base[i];
      end
    end
  endfunction

  // One transaction. rdy: cycles of o_tgt_valid before the target accepts;
  // rsp: further cycles until read data is returned (0 = same cycle).
  task automatic txn(input logic [29:0] a, input logic [31:0] d, input logic w,
                     input logic [3:0] m, input int rdy, input int rsp,
                     input logic [31:0] rword);
    bit          hit;
    int          idx;
    logic [29:0] off;
    logic [NR-1:0] oh;
    int          done, rsp_cycle, req_last, last_drive, n;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [NR-1:0] noise;

    ref_decode(use_b, a, hit, idx, off);
    oh = hit ? (NR'(1) << idx) : '0;
    if (!hit) begin
      rsp_cycle = 0; req_last = -1; exp_err = 1; exp_data = '0;
    end else begin
      done     = w ? rdy : rdy + rsp;
      req_last = (rdy < TO) ? rdy : TO - 1;
      if (done >= TO) begin
        rsp_cycle = TO; exp_err = 1; exp_data = '0;
      end else begin
        rsp_cycle = done + 1; exp_err = 0; exp_data = w ? 32'h0 : rword;
      end
    end

    chk("req_ready_idle", 64'(m_req_ready), 64'd1);
    req_valid = 1'b1; addr = a; wdata = d; wren = w; mask = m;
    @(negedge clk);
    // Scramble request inputs to show the target side uses latched copies.
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; wren = 1'($urandom); mask = 4'($urandom);

    last_drive = hit ? rdy + rsp : 0;
    n = ((rsp_cycle > last_drive) ? rsp_cycle : last_drive) + 2;
    for (int c = 0; c <= n; c++) begin
      chk("tgt_valid", 64'(m_tgt_valid), 64'((hit && c <= req_last) ? oh : '0));
      if (hit && c <= req_last) begin
        chk("tgt_addr", 64'(m_tgt_addr), 64'(off));
        chk("tgt_data", 64'(m_tgt_data), 64'(d));
        chk("tgt_wren", 64'(m_tgt_wren), 64'(w));
        chk("tgt_mask", 64'(m_tgt_mask), 64'(m));
      end
      chk("rsp_valid", 64'(m_rsp_valid), 64'(c == rsp_cycle));
      chk("req_ready", 64'(m_req_ready), 64'(c > rsp_cycle));
      if (c >= rsp_cycle) begin
        chk("rsp_data", 64'(m_rsp_data), 64'(exp_data));
        chk("rsp_err", 64'(m_rsp_err), 64'(exp_err));
      end
      // Non-selected targets toggle freely; the selected one follows rdy/rsp.
      noise = NR'($urandom);
      tgt_ready = hit ? ((noise & ~oh) | ((c == rdy) ? oh : '0)) : noise;
      noise = NR'($urandom);
      tgt_rsp_valid = hit ? ((noise & ~oh) | ((!w && c == rdy + rsp) ? oh : '0)) : noise;
      tgt_rsp_data = {$urandom, $urandom};
      if (hit && c == rdy + rsp) tgt_rsp_data[32*idx +: 32] = rword;
      @(negedge clk);
    end
    tgt_ready = '0; tgt_rsp_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] ra;
    int          sel;
    int          rd;
    req_valid = 0; addr = '0; wdata = '0; wren = 0; mask = '0;
    tgt_ready = '0; tgt_rsp_valid = '0; tgt_rsp_data = '0;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(m_req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(m_rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(m_rsp_err), 64'd0);
    chk("rst_tgt_valid", 64'(m_tgt_valid), 64'd0);
    chk("rst_tgt_addr", 64'(m_tgt_addr), 64'd0);
    chk("rst_tgt_data", 64'(m_tgt_data), 64'd0);
    chk("rst_tgt_wren", 64'(m_tgt_wren), 64'd0);
    chk("rst_tgt_mask", 64'(m_tgt_mask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(m_req_ready), 64'd1);

    // Directed: DMEM read, MMIO write, unmapped, timeout with late response
    txn(30'h00010, 32'h0, 1'b0, 4'hF, 0, 2, 32'hDEADBEEF);
    txn(30'h00404, 32'h12345678, 1'b1, 4'b0011, 2, 0, 32'h0);
    txn(30'h00600, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0);
    txn(30'h00020, 32'h0, 1'b0, 4'hF, 40, 2, 32'hCAFEF00D);
    txn(30'h00030, 32'h0, 1'b0, 4'hF, 3, 0, 32'h0BADF00D);
    txn(30'h003FF, 32'h0, 1'b0, 4'hF, 1, 14, 32'h55AA55AA);
    txn(30'h004FF, 32'hA5A5A5A5, 1'b1, 4'b1000, 0, 0, 32'h0);
    txn(30'h00500, 32'h0, 1'b1, 4'hF, 0, 0, 32'h0);

    // Randomized transactions across both regions, boundaries and holes
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: ra = 30'($urandom_range(0, 32'h3FF));
        1: ra = 30'($urandom_range(32'h400, 32'h4FF));
        2: ra = 30'($urandom_range(32'h500, 32'h3FFF_FFFF));
        default: begin
          rd = $urandom_range(0, 3);
          ra = (rd == 0) ? 30'h003FF : (rd == 1) ? 30'h00400 :
               (rd == 2) ? 30'h004FF : 30'h00500;
        end
      endcase
      rd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 10);
      txn(ra, $urandom, 1'($urandom), 4'($urandom), rd, $urandom_range(0, 8), $urandom);
    end

    // Asynchronous reset while a read waits for its data
    chk("req_ready_idle", 64'(m_req_ready), 64'd1);
    req_valid = 1'b1; addr = 30'h00040; wren = 1'b0; mask = 4'hF; wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    tgt_ready = 2'b01;
    @(negedge clk);
    tgt_ready = '0;
    @(negedge clk);
    chk("wait_tgt_valid", 64'(m_tgt_valid), 64'd0);
    chk("wait_tgt_addr", 64'(m_tgt_addr), 64'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tgt_addr", 64'(m_tgt_addr), 64'd0);
    chk("arst_tgt_mask", 64'(m_tgt_mask), 64'd0);
    chk("arst_rsp_data", 64'(m_rsp_data), 64'd0);
    chk("arst_rsp_err", 64'(m_rsp_err), 64'd0);
    chk("arst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    chk("arst_req_ready", 64'(m_req_ready), 64'd0);
    tgt_rsp_valid = 2'b01; tgt_rsp_data = {32'h0, 32'h11112222};
    @(negedge clk);
    chk("arst_no_rsp", 64'(m_rsp_valid), 64'd0);
    rst_n = 1'b1;
    tgt_rsp_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rel_no_rsp", 64'(m_rsp_valid), 64'd0);
      chk("rel_tgt_valid", 64'(m_tgt_valid), 64'd0);
      chk("rel_req_ready", 64'(m_req_ready), 64'd1);
    end
    txn(30'h00010, 32'h0, 1'b0, 4'hF, 1, 1, 32'h87654321);

    // Overlapping map: region 1 starts at 0x3F0 inside region 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    use_b = 1'b1;
    @(negedge clk);
    txn(30'h003F8, 32'h0, 1'b0, 4'hF, 0, 1, 32'h13579BDF);
    txn(30'h003FF, 32'hFEEDFACE, 1'b1, 4'b0101, 1, 0, 32'h0);
    txn(30'h00400, 32'h0, 1'b0, 4'hF, 0, 0, 32'h2468ACE0);
    txn(30'h003EF, 32'h0, 1'b0, 4'hF, 2, 3, 32'h0F0F0F0F);
    for (int t = 0; t < 6; t++) begin
      ra = 30'($urandom_range(32'h3E0, 32'h520));
      txn(ra, $urandom, 1'($urandom), 4'($urandom), $urandom_range(0, 6),
          $urandom_range(0, 6), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_xbar_n.md
Name: mem_xbar_n

Overview:
- Parametrised successor to the 2-way data/MMIO address decoder, for the CPU data port.
- Routes one CPU word request to one of NUM_REGIONS targets (DMEM, MMIO, ROM, peripherals).
- Adds a valid/ready request handshake and multi-cycle target responses.
- Adds an error response for unmapped addresses and a per-transaction timeout.
- Single outstanding transaction; sits between the CPU load/store unit and the memory targets.

Parameters:
- NUM_REGIONS, 2, number of targets (1..8).
- REGION_BASE, {30'h00400, 30'h00000}, packed NUM_REGIONS*30 word base addresses; region k in bits [30k+29:30k].
- REGION_LIMIT, {30'h00500, 30'h00400}, packed exclusive word limits, same packing.
- TIMEOUT, 16, max cycles waiting on a target before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_addr  in  30  word address.
- i_data  in  32  write data.
- i_wren  in  1  1=write, 0=read.
- i_mask  in  4  byte-enable mask.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_data  out  32  read data.
- o_rsp_err  out  1  unmapped access or timeout.
- o_tgt_valid  out  NUM_REGIONS  one-hot target request.
- o_tgt_addr  out  30  region-relative address (i_addr - base).
- o_tgt_data  out  32  latched write data.
- o_tgt_wren  out  1  latched write enable.
- o_tgt_mask  out  4  latched byte mask.
- i_tgt_ready  in  NUM_REGIONS  per-target request accept.
- i_tgt_rsp_valid  in  NUM_REGIONS  per-target read data valid.
- i_tgt_rsp_data  in  NUM_REGIONS*32  per-target read data, packed.

Behaviour:
- Reset (rst_n low, async): state IDLE; o_req_ready=1 once out of reset; o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_tgt_valid=0, o_tgt_addr=0, o_tgt_data=0, o_tgt_wren=0, o_tgt_mask=0; timeout counter=0.
- Decode: region k hits when REGION_BASE[k] <= addr < REGION_LIMIT[k] (unsigned, 30-bit). Overlapping regions: the lowest index wins.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch addr-base, data, wren, mask and the region index.
  - Hit: go to REQ and assert o_tgt_valid[k] from the next cycle.
  - Miss: go to RESP with err=1, data=0. No o_tgt_valid is ever asserted.
- REQ: hold o_tgt_valid[k] and all o_tgt_* stable until i_tgt_ready[k]=1.
  - Write handshake: go to RESP, err=0, data=0.
  - Read handshake: go to WAIT.
  - o_tgt_valid drops in the cycle after the handshake.
- WAIT: on i_tgt_rsp_valid[k], capture i_tgt_rsp_data[k] and go to RESP, err=0. Response signals from non-selected targets are ignored.
  - A response arriving in the same cycle as the REQ handshake (zero-latency target) is captured; go directly to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle with data/err; then IDLE.
  - o_rsp_data and o_rsp_err hold their values until the next response.
  - o_req_ready=0 in REQ, WAIT and RESP, so the minimum request-to-request spacing is 3 cycles for a hit and 2 for a miss.
- Timeout (TIMEOUT>0): the counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT with no completion, deassert o_tgt_valid and go to RESP with err=1, data=0.
  - If completion and timeout occur in the same cycle, completion wins.
  - A late target response after timeout is ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No response is emitted for the aborted request.
- Width rule: o_tgt_addr is a 30-bit subtraction and wraps modulo 2^30 (cannot occur for valid hits).

Test Plan:
- Read DMEM, defaults: req addr 30'h00010 read; target0 ready in the same cycle as valid, rsp_valid 2 cycles later with 32'hDEADBEEF.
  - Required: o_tgt_addr=30'h00010, one o_rsp_valid pulse with data DEADBEEF, err=0.
- Write MMIO: addr 30'h00404, data 32'h12345678, mask 4'b0011; target1 ready after 3 cycles.
  - Required: o_tgt_valid=2'b10 held 3 cycles, o_tgt_addr=30'h4, mask 0011; then rsp_valid with err=0; o_req_ready=0 throughout.
- Unmapped: addr 30'h00600 read.
  - Required: o_tgt_valid stays 0; o_rsp_valid exactly one cycle after acceptance with err=1, data=0.
- Timeout: TIMEOUT=16, read to region0, target never ready.
  - Required: o_tgt_valid high 16 cycles then low; rsp err=1.
  - A later i_tgt_rsp_valid[0] produces no response.
- Overlap/boundary: region1 base 30'h003F0 overlapping region0; access 30'h003F8.
  - Required: region0 selected.
  - Access 30'h003FF hits region0; access 30'h00400 hits region1 with o_tgt_addr=30'h10.
- Reset mid-WAIT: assert rst_n=0 asynchronously mid-cycle.
  - Required: outputs zero immediately, no rsp pulse, o_req_ready=1 after release.
